// File: rtl/tpu_pkg.sv
// Shared widths, array geometry and lane helpers for the systolic array and its PEs.
package tpu_pkg;

    localparam int unsigned DATA_BITS       = 8;
    localparam int unsigned IN_BITS         = DATA_BITS * 2;
    localparam int unsigned ACC_BITS        = DATA_BITS * 4;
    localparam int unsigned ARRAY_DIM       = 4;
    localparam int unsigned LB_IN_BITS      = IN_BITS * ARRAY_DIM;
    localparam int unsigned LB_OUT_BITS     = ACC_BITS * ARRAY_DIM;
    localparam int unsigned LAST_FEED_CYCLE = 9;
    localparam int unsigned DONE_CNT        = 11;
    localparam int unsigned CNT_BITS        = 4;

    typedef logic signed [IN_BITS-1:0]  operand_t;
    typedef logic signed [ACC_BITS-1:0] acc_t;
    typedef logic [CNT_BITS-1:0]        cnt_t;

    // Lane 0 sits in the most significant slice of a buffer word.
    function automatic operand_t in_lane(input logic [LB_IN_BITS-1:0] word, input int idx);
        return operand_t'(word[(ARRAY_DIM - 1 - idx) * IN_BITS +: IN_BITS]);
    endfunction

    function automatic logic [LB_OUT_BITS-1:0] out_lane_mask(input int idx);
        logic [LB_OUT_BITS-1:0] mask;
        mask = '0;
        mask[(ARRAY_DIM - 1 - idx) * ACC_BITS +: ACC_BITS] = '1;
        return mask;
    endfunction

endpackage

// File: rtl/sa_pe.sv
// Output-stationary processing element: multiply-accumulate plus east/south operand forwarding.
module sa_pe
    import tpu_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     clr,
    input  logic     en,
    input  operand_t a_in,
    input  operand_t b_in,
    output operand_t a_out,
    output operand_t b_out,
    output acc_t     acc
);

    operand_t a_q, a_d;
    operand_t b_q, b_d;
    acc_t     acc_q, acc_d;

    always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        acc_d = acc_q;
        if (clr) begin
            a_d   = '0;
            b_d   = '0;
            acc_d = '0;
        end else if (en) begin
            a_d   = a_in;
            b_d   = b_in;
            // Sign-extend before multiplying so the full 32-bit product wraps into acc.
            acc_d = acc_q + acc_t'(a_in) * acc_t'(b_in);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            acc_q <= acc_d;
        end
    end

    assign a_out = a_q;
    assign b_out = b_q;
    assign acc   = acc_q;

endmodule

// File: rtl/systolic_array_4x4.sv
// 4x4 output-stationary signed MAC array: skews A columns / B rows into the PE grid,
// counts the feed/drain cycles and flags the finished tile.
module systolic_array_4x4 #(
    parameter int unsigned DATA_BITS   = 8,
    parameter int unsigned IN_BITS     = DATA_BITS * 2,
    parameter int unsigned ACC_BITS    = DATA_BITS * 4,
    parameter int unsigned LB_IN_BITS  = IN_BITS * 4,
    parameter int unsigned LB_OUT_BITS = ACC_BITS * 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   sa_rst_n,
    input  logic [LB_IN_BITS-1:0]  local_buffer_A0,
    input  logic [LB_IN_BITS-1:0]  local_buffer_A1,
    input  logic [LB_IN_BITS-1:0]  local_buffer_A2,
    input  logic [LB_IN_BITS-1:0]  local_buffer_A3,
    input  logic [LB_IN_BITS-1:0]  local_buffer_B0,
    input  logic [LB_IN_BITS-1:0]  local_buffer_B1,
    input  logic [LB_IN_BITS-1:0]  local_buffer_B2,
    input  logic [LB_IN_BITS-1:0]  local_buffer_B3,
    output logic [LB_OUT_BITS-1:0] local_buffer_C0,
    output logic [LB_OUT_BITS-1:0] local_buffer_C1,
    output logic [LB_OUT_BITS-1:0] local_buffer_C2,
    output logic [LB_OUT_BITS-1:0] local_buffer_C3,
    output logic                   done
);

    import tpu_pkg::*;

    logic [LB_IN_BITS-1:0]  a_buf [ARRAY_DIM];
    logic [LB_IN_BITS-1:0]  b_buf [ARRAY_DIM];
    logic [LB_OUT_BITS-1:0] c_row [ARRAY_DIM];

    cnt_t cnt_q, cnt_d;
    logic done_q, done_d;
    logic run;
    logic clr;

    operand_t west  [ARRAY_DIM];
    operand_t north [ARRAY_DIM];
    operand_t a_h   [ARRAY_DIM][ARRAY_DIM+1];
    operand_t b_v   [ARRAY_DIM+1][ARRAY_DIM];
    acc_t     acc   [ARRAY_DIM][ARRAY_DIM];
    logic     unused_edge;

    assign a_buf[0] = local_buffer_A0;
    assign a_buf[1] = local_buffer_A1;
    assign a_buf[2] = local_buffer_A2;
    assign a_buf[3] = local_buffer_A3;
    assign b_buf[0] = local_buffer_B0;
    assign b_buf[1] = local_buffer_B1;
    assign b_buf[2] = local_buffer_B2;
    assign b_buf[3] = local_buffer_B3;

    assign clr = ~sa_rst_n;
    assign run = sa_rst_n && (cnt_q < cnt_t'(DONE_CNT));

    always_comb begin
        cnt_d  = cnt_q;
        done_d = done_q;
        if (clr) begin
            cnt_d  = '0;
            done_d = 1'b0;
        end else if (run) begin
            cnt_d  = cnt_q + cnt_t'(1);
            // Only cnt=10 satisfies this while running: the edge after PE(3,3)'s last product.
            done_d = done_q | (cnt_q > cnt_t'(LAST_FEED_CYCLE));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    // Skew: row r / column c lags by r / c cycles, zero outside its 4-cycle window.
    always_comb begin
        for (int i = 0; i < int'(ARRAY_DIM); i++) begin
            int k;
            k = int'(cnt_q) - i;
            west[i]  = '0;
            north[i] = '0;
            if (k >= 0 && k < int'(ARRAY_DIM)) begin
                west[i]  = in_lane(a_buf[k[1:0]], i);
                north[i] = in_lane(b_buf[k[1:0]], i);
            end
        end
    end

    for (genvar r = 0; r < ARRAY_DIM; r++) begin : g_row
        assign a_h[r][0] = west[r];
        assign b_v[0][r] = north[r];
        for (genvar c = 0; c < ARRAY_DIM; c++) begin : g_col
            sa_pe u_pe (
                .clk   (clk),
                .rst   (rst),
                .clr   (clr),
                .en    (run),
                .a_in  (a_h[r][c]),
                .b_in  (b_v[r][c]),
                .a_out (a_h[r][c+1]),
                .b_out (b_v[r+1][c]),
                .acc   (acc[r][c])
            );
        end
    end

    // Operands leaving the east and south edges have no consumer.
    always_comb begin
        unused_edge = 1'b0;
        for (int i = 0; i < int'(ARRAY_DIM); i++) begin
            unused_edge = unused_edge ^ (^a_h[i][ARRAY_DIM]) ^ (^b_v[ARRAY_DIM][i]);
        end
    end

    always_comb begin
        for (int r = 0; r < int'(ARRAY_DIM); r++) begin
            c_row[r] = '0;
            for (int c = 0; c < int'(ARRAY_DIM); c++) begin
                c_row[r] = c_row[r] | (out_lane_mask(c)
                           & {ARRAY_DIM{acc[r][c]}});
            end
        end
    end

    assign local_buffer_C0 = c_row[0];
    assign local_buffer_C1 = c_row[1];
    assign local_buffer_C2 = c_row[2];
    assign local_buffer_C3 = c_row[3];
    assign done            = done_q;

endmodule

// File: tb/tb_systolic_array_4x4.sv
// Self-checking bench: directed and random tiles compared against a plain matrix-product model.
module tb_systolic_array_4x4;

    logic         clk = 1'b0;
    logic         rst;
    logic         sa_rst_n;
    logic [63:0]  a_buf [4];
    logic [63:0]  b_buf [4];
    logic [127:0] c_out [4];
    logic         done;

    int checks = 0;
    int errors = 0;
    int am [4][4];
    int bm [4][4];

    always #5 clk = ~clk;

    systolic_array_4x4 dut (
        .clk             (clk),
        .rst             (rst),
        .sa_rst_n        (sa_rst_n),
        .local_buffer_A0 (a_buf[0]),
        .local_buffer_A1 (a_buf[1]),
        .local_buffer_A2 (a_buf[2]),
        .local_buffer_A3 (a_buf[3]),
        .local_buffer_B0 (b_buf[0]),
        .local_buffer_B1 (b_buf[1]),
        .local_buffer_B2 (b_buf[2]),
        .local_buffer_B3 (b_buf[3]),
        .local_buffer_C0 (c_out[0]),
        .local_buffer_C1 (c_out[1]),
        .local_buffer_C2 (c_out[2]),
        .local_buffer_C3 (c_out[3]),
        .done            (done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pack();
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 4; i++) begin
                a_buf[k][(3 - i) * 16 +: 16] = am[i][k][15:0];
                b_buf[k][(3 - i) * 16 +: 16] = bm[k][i][15:0];
            end
        end
    endtask

    function automatic int model(input int r, input int c);
        int s = 0;
        for (int k = 0; k < 4; k++) s += am[r][k] * bm[k][c];
        return s;
    endfunction

    task automatic check_result(input string tag);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                chk($sformatf("%s C[%0d][%0d]", tag, r, c), c_out[r][(3 - c) * 32 +: 32],
                    model(r, c));
    endtask

    task automatic check_zero(input string tag);
        chk({tag, " done"}, {31'b0, done}, 32'd0);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                chk($sformatf("%s zero C[%0d][%0d]", tag, r, c), c_out[r][(3 - c) * 32 +: 32],
                    32'd0);
    endtask

    // Assumes the array is cleared and sa_rst_n is high; runs 11 edges then checks the tile.
    task automatic run_edges(input string tag);
        for (int e = 1; e <= 11; e++) begin
            tick();
            chk($sformatf("%s done@edge%0d", tag, e), {31'b0, done}, (e == 11) ? 32'd1 : 32'd0);
        end
        check_result(tag);
        repeat (3) tick();
        chk({tag, " done held"}, {31'b0, done}, 32'd1);
        check_result({tag, " hold"});
    endtask

    task automatic run_tile(input string tag);
        pack();
        sa_rst_n = 1'b0;
        tick();
        check_zero({tag, " clr"});
        sa_rst_n = 1'b1;
        run_edges(tag);
    endtask

    task automatic fill(input int av, input int bv);
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                am[i][j] = av;
                bm[i][j] = bv;
            end
    endtask

    initial begin
        logic [15:0] t16;
        rst      = 1'b1;
        sa_rst_n = 1'b0;
        for (int k = 0; k < 4; k++) begin
            a_buf[k] = {$urandom, $urandom};
            b_buf[k] = {$urandom, $urandom};
        end
        repeat (2) tick();
        check_zero("reset");

        // rst wins over sa_rst_n=1
        sa_rst_n = 1'b1;
        repeat (12) tick();
        check_zero("rst_over_run");
        rst = 1'b0;

        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                am[i][j] = (i == j) ? 1 : 0;
                bm[i][j] = i * 4 + j + 1;
            end
        run_tile("identity");

        fill(1, 1);
        run_tile("ones");

        fill(-128, 127);
        run_tile("signed");

        fill(32'h7FFF, 32'h7FFF);
        run_tile("wrap");
        chk("wrap literal", c_out[2][31:0], 32'hFFFC0004);

        for (int n = 0; n < 4; n++) begin
            for (int i = 0; i < 4; i++)
                for (int j = 0; j < 4; j++) begin
                    t16 = 16'($urandom);
                    am[i][j] = int'($signed(t16));
                    t16 = 16'($urandom);
                    bm[i][j] = int'($signed(t16));
                end
            run_tile($sformatf("rand%0d", n));
        end

        // Abort at cnt=5, then rerun from t=0
        fill(1, 1);
        pack();
        sa_rst_n = 1'b0;
        tick();
        sa_rst_n = 1'b1;
        repeat (5) tick();
        sa_rst_n = 1'b0;
        tick();
        check_zero("abort");
        sa_rst_n = 1'b1;
        run_edges("abort_rerun");

        // rst pulse at cnt=7 while running
        fill(3, -2);
        pack();
        sa_rst_n = 1'b0;
        tick();
        sa_rst_n = 1'b1;
        repeat (7) tick();
        rst = 1'b1;
        tick();
        check_zero("rst_mid");
        rst = 1'b0;
        run_edges("rst_mid_rerun");

        // rst pulse after done
        rst = 1'b1;
        tick();
        check_zero("rst_after_done");
        rst = 1'b0;
        run_edges("rst_done_rerun");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/systolic_array_4x4.md
# systolic_array_4x4

Output-stationary 4x4 signed multiply-accumulate array that sits directly downstream of the TPU control FSM. It consumes the four A-column and four B-row local buffers the FSM loads, skews them into a grid of 16 processing elements, and computes one 4x4 partial tile product per K-block. It then raises `done` and presents the four accumulated result rows back to the FSM.

## Interface
Parameters:
- `DATA_BITS`, 8: raw operand width in global buffers.
- `IN_BITS`, `DATA_BITS*2` (16): signed operand lane width.
- `ACC_BITS`, `DATA_BITS*4` (32): signed accumulator width.
- `LB_IN_BITS`, `IN_BITS*4` (64): input buffer word width.
- `LB_OUT_BITS`, `ACC_BITS*4` (128): output row width.

Ports:
- `clk`, in, 1: single clock. All state updates on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `sa_rst_n`, in, 1: run enable. Low clears the array synchronously. High runs the array.
- `local_buffer_A0..A3`, in, 64 each: `local_buffer_Ak` holds `A[r][k]` for r=0..3. Row 0 is in bits [63:48]; row 3 is in bits [15:0].
- `local_buffer_B0..B3`, in, 64 each: `local_buffer_Bk` holds `B[k][c]`. Column 0 is in bits [63:48].
- `local_buffer_C0..C3`, out, 128 each: `local_buffer_Cr` is result row r. Column 0 is in bits [127:96]. Each lane is a 32-bit signed value.
- `done`, out, 1: tile complete. Held high until the array is cleared.

## Operation
- Clear condition is `rst` or `!sa_rst_n`. On clear:
  - all 16 accumulators, all skew/forwarding registers, the cycle counter `cnt` and `done` go to 0.
  - `rst` has priority over every other input.
- Run: each edge with `sa_rst_n`=1 and `cnt`<11 increments `cnt`. `cnt` saturates at 11.
- Feed (t = `cnt` before the edge):
  - row r west input = `A[r][t-r]` when 0 ≤ t-r ≤ 3, else 0.
  - column c north input = `B[t-c][c]` when 0 ≤ t-c ≤ 3, else 0.
- PE (`sa_pe`), every run edge:
  - `acc += a_in*b_in`
  - `a_out <= a_in` (east), `b_out <= b_in` (south).
- PE(r,c) sees `A[r][k]`/`B[k][c]` paired at t = k+r+c. The last useful product is at t=9, in PE(3,3).
- Arithmetic:
  - 16x16 signed multiply gives a full 32-bit product.
  - The accumulator adds at 32 bits and wraps modulo 2^32; no saturation.
- `done` is registered. It is set on the edge where `cnt` goes 10→11, after all 16 accumulators are final.
- The array keeps its state while `cnt`=11 and `sa_rst_n`=1. Accumulators stop updating after `cnt`=11.
- `local_buffer_Cr` lane c = `acc[r][c]` continuously (register outputs). The values are valid whenever `done`=1.
- Operands must be held stable by upstream while `sa_rst_n`=1. The array does not latch them.

## Timing
- Reset value of every output: `local_buffer_C0..C3` = 0, `done` = 0.
- Latency: `done` rises on the 11th rising edge at which `sa_rst_n`=1 is sampled, counted from clear.
- The FSM reads C while `done`=1 and drops `sa_rst_n` on the next state. The clear takes effect at the following edge, so the FSM must capture C before or on that edge.
- Aborted run: `sa_rst_n` low for one edge at any `cnt` → full clear at that edge. The next high run restarts at t=0.
- `rst` mid-run: full clear at that edge; `done` = 0 the following cycle.
- `sa_rst_n` held high with unchanged operands after `done`: no further accumulation; outputs are stable indefinitely.
- Simultaneous `rst`=1 and `sa_rst_n`=1: clear wins.

## Structure
- Shared package `tpu_pkg`, holding:
  - `DATA_BITS`, `IN_BITS`, `ACC_BITS`
  - `ARRAY_DIM`=4, `LAST_FEED_CYCLE`=9, `DONE_CNT`=11
  - lane slice helpers and typedefs `operand_t` (signed 16) and `acc_t` (signed 32).
- One sub-module, `sa_pe`. Ports: `clk`, `rst`, `clr`, `en`, `a_in`, `b_in`, `a_out`, `b_out`, `acc`. It is instantiated 4x4 via generate.
- Top level contains the counter, the skew muxes, `done` generation and output packing.

## Test plan
- Identity A (diagonal 1), B rows = {1,2,3,4}, {5,6,7,8}, {9,10,11,12}, {13,14,15,16} → `done` at edge 11. C rows equal the B rows.
- All lanes A=1, B=1 → every C lane = 4. `done` = 0 before edge 11 and 1 from edge 11 while `sa_rst_n` is high.
- Signed values: A all -128, B all 127 → every lane = -65024 (0xFFFF0200).
- Wrap: A all 0x7FFF, B all 0x7FFF → each lane = 4*0x3FFF0001 mod 2^32 = 0xFFFC0004.
- Abort: drop `sa_rst_n` at `cnt`=5 for one edge, then rerun all-ones → C = 4 everywhere, `done` at 11 edges after restart.
- `rst` pulse at `cnt`=7 and again after `done` → C = 0 and `done` = 0 the next cycle. A rerun reproduces the correct result.
